// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
// Receive end of the systolic array result interface. Column c of the array
// produces its results one cycle after column c-1; this block buffers each
// column in a small FIFO and releases a full row once every active column has
// a sample waiting, so the unified buffer sees one aligned row per transfer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sys_data_in         WIDTH signed results, column c at [c*DATA_W +: DATA_W]
//   sys_valid_in        per-column result valid
//   col_size_in/_valid  number of active columns (0 -> 1, > WIDTH -> WIDTH)
//   row_count_in        rows expected in the job, latched by start_in
//   start_in            arms a job (honoured only when idle)
//   out_data/_valid     aligned row toward the unified buffer, inactive fields 0
//   out_ready           downstream accepts the row
//   out_row_idx         0-based index of the row currently on out_data
//   busy_out            job in progress
//   done_out            one-cycle pulse after the last row is accepted
//   overflow_out        sticky until next start: a sample hit a full FIFO
module systolic_output_deskew #(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*DATA_W-1:0] sys_data_in,
  input  logic [WIDTH-1:0]        sys_valid_in,
  input  logic [15:0]             col_size_in,
  input  logic                    col_size_valid_in,
  input  logic [15:0]             row_count_in,
  input  logic                    start_in,
  output logic [WIDTH*DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_row_idx,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    overflow_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] col_size;
  logic [15:0] job_cols;
  logic [15:0] row_count;
  logic [15:0] row_idx;

  logic signed [DATA_W-1:0] mem [WIDTH][DEPTH];
  logic [PTR_W-1:0]         wr_ptr [WIDTH];
  logic [PTR_W-1:0]         rd_ptr [WIDTH];
  logic [CNT_W-1:0]         cnt    [WIDTH];

  logic [WIDTH-1:0] active, nonempty, full, push_req, push, pop;
  logic             all_ready, xfer, drop, last_row, start_job;

  // Requested column counts are clamped into 1..WIDTH.
  function automatic logic [15:0] clamp_cols(input logic [15:0] v);
    if (v == 16'd0)
      return 16'd1;
    else if (v > 16'(WIDTH))
      return 16'(WIDTH);
    else
      return v;
  endfunction

  always_comb begin
    active   = '0;
    nonempty = '0;
    full     = '0;
    push_req = '0;
    for (int c = 0; c < WIDTH; c++) begin
      active[c]   = (c < int'(job_cols));
      nonempty[c] = (cnt[c] != '0);
      full[c]     = (cnt[c] == CNT_W'(DEPTH));
      push_req[c] = (state == COLLECT) && sys_valid_in[c] && active[c];
    end
    // Inactive columns never block a row.
    all_ready = &(nonempty | ~active);
    out_valid = (state == COLLECT) && all_ready;
    xfer      = out_valid && out_ready;
    pop       = xfer ? active : '0;
    // A full FIFO still accepts a push in the cycle it is also popped.
    push      = push_req & (~full | pop);
    drop      = |(push_req & full & ~pop);
    last_row  = xfer && (row_idx == row_count - 16'd1);
    start_job = (state == IDLE) && start_in;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = (row_count_in == 16'd0) ? DONE : COLLECT;
      COLLECT: if (last_row) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (out_valid && active[c])
        out_data[c*DATA_W +: DATA_W] = mem[c][rd_ptr[c]];
    end
  end

  assign out_row_idx = row_idx;
  assign busy_out    = (state == COLLECT);
  assign done_out    = (state == DONE);

  // Control state: FSM, job registers, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col_size     <= 16'(WIDTH);
      job_cols     <= 16'(WIDTH);
      row_count    <= '0;
      row_idx      <= '0;
      overflow_out <= 1'b0;
      for (int c = 0; c < WIDTH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      state <= state_next;
      if (col_size_valid_in)
        col_size <= clamp_cols(col_size_in);
      if (start_job) begin
        job_cols  <= col_size;
        row_count <= row_count_in;
        row_idx   <= '0;
      end else if (xfer) begin
        row_idx <= row_idx + 16'd1;
      end
      if (start_job)
        overflow_out <= 1'b0;
      else if (drop)
        overflow_out <= 1'b1;
      for (int c = 0; c < WIDTH; c++) begin
        // Leftover samples are discarded on the way into DONE.
        if (state_next == DONE) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          cnt[c]    <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
          cnt[c] <= cnt[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
        end
      end
    end
  end

  // Sample storage: data only, no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < WIDTH; c++) begin
      if (push[c])
        mem[c][wr_ptr[c]] <= $signed(sys_data_in[c*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: tb/tb_systolic_output_deskew.sv
module tb_systolic_output_deskew;

  localparam int W  = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W*DW-1:0] sys_data;
  logic [W-1:0]  sys_valid;
  logic [15:0]   col_size;
  logic          col_size_valid;
  logic [15:0]   row_count;
  logic          start;
  logic          out_ready;

  logic [W*DW-1:0] a_data, b_data;
  logic          a_valid, b_valid, a_busy, b_busy, a_done, b_done, a_ovf, b_ovf;
  logic [15:0]   a_idx, b_idx;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Deep FIFOs for the main scenarios.
  systolic_output_deskew #(.WIDTH(W), .DATA_W(DW), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .sys_data_in(sys_data), .sys_valid_in(sys_valid),
    .col_size_in(col_size), .col_size_valid_in(col_size_valid),
    .row_count_in(row_count), .start_in(start),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .out_row_idx(a_idx), .busy_out(a_busy), .done_out(a_done), .overflow_out(a_ovf));

  // Two-entry FIFOs for the overflow scenario.
  systolic_output_deskew #(.WIDTH(W), .DATA_W(DW), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .sys_data_in(sys_data), .sys_valid_in(sys_valid),
    .col_size_in(col_size), .col_size_valid_in(col_size_valid),
    .row_count_in(row_count), .start_in(start),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
    .out_row_idx(b_idx), .busy_out(b_busy), .done_out(b_done), .overflow_out(b_ovf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
    sys_valid = v;
    sys_data  = {d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(2'b00, 16'd0, 16'd0);
    col_size = '0; col_size_valid = 1'b0; row_count = '0; start = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_col(input logic [15:0] c);
    col_size = c; col_size_valid = 1'b1;
    step();
    col_size_valid = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] n);
    start = 1'b1; row_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_data, a_valid, a_idx, a_busy, a_done, a_ovf} !== '0)
      $display("FAIL reset_a: got data=%h v=%b idx=%0d busy=%b done=%b ovf=%b, want all 0",
               a_data, a_valid, a_idx, a_busy, a_done, a_ovf);
    else passes++;
    checks++;
    if ({b_data, b_valid, b_idx, b_busy, b_done, b_ovf} !== '0)
      $display("FAIL reset_b: got data=%h v=%b idx=%0d, want all 0", b_data, b_valid, b_idx);
    else passes++;
  endtask

  task automatic test_single_row();
    do_reset();
    set_col(16'd2);
    start_job(16'd1);
    checks++;
    if (a_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", a_busy); else passes++;
    drv(2'b01, 16'd10, 16'd0); step();
    checks++;
    if (a_valid !== 1'b0) $display("FAIL single_early: out_valid %b want 0", a_valid); else passes++;
    drv(2'b10, 16'd0, 16'd20); step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== {16'd20, 16'd10} || a_idx !== 16'd0)
      $display("FAIL single_row: v=%b data=%h idx=%0d want v=1 data=0014000a idx=0", a_valid, a_data, a_idx);
    else passes++;
    out_ready = 1'b1; drv(2'b00, 16'd0, 16'd0); step();
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0)
      $display("FAIL single_done: done=%b busy=%b v=%b want 1 0 0", a_done, a_busy, a_valid);
    else passes++;
    step();
    checks++;
    if (a_done !== 1'b0) $display("FAIL single_done_pulse: done=%b want 0", a_done); else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int dones;
    do_reset();
    set_col(16'd2);
    start_job(16'd3);
    drv(2'b01, 16'd1, 16'd0); step();
    drv(2'b11, 16'd3, 16'd2); step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_valid !== 1'b1 || a_data !== {16'd2, 16'd1} || a_idx !== 16'd0)
        $display("FAIL hold_%0d: v=%b data=%h idx=%0d want v=1 data=00020001 idx=0", k, a_valid, a_data, a_idx);
      else passes++;
      if (k == 0) drv(2'b11, 16'd5, 16'd4);
      else if (k == 1) drv(2'b10, 16'd0, 16'd6);
      else drv(2'b00, 16'd0, 16'd0);
      step();
    end
    out_ready = 1'b1;
    dones = 0;
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (a_valid !== 1'b1 || a_data !== {16'(2*r+2), 16'(2*r+1)} || a_idx !== 16'(r))
        $display("FAIL bp_row%0d: v=%b data=%h idx=%0d want v=1 data=%h idx=%0d",
                 r, a_valid, a_data, a_idx, {16'(2*r+2), 16'(2*r+1)}, r);
      else passes++;
      if (a_done) dones++;
      step();
    end
    for (int k = 0; k < 3; k++) begin
      if (a_done) dones++;
      step();
    end
    checks++;
    if (dones !== 1) $display("FAIL bp_done_count: got %0d want 1", dones); else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_col_size();
    logic [15:0] g;
    do_reset();
    set_col(16'd1);
    start_job(16'd2);
    out_ready = 1'b1;
    g = 16'($urandom_range(1, 16'hffff));
    drv(2'b11, 16'd11, g); step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== {16'd0, 16'd11} || a_idx !== 16'd0)
      $display("FAIL cs1_row0: v=%b data=%h idx=%0d want 1 0000000b 0", a_valid, a_data, a_idx);
    else passes++;
    g = 16'($urandom_range(1, 16'hffff));
    drv(2'b11, 16'd12, g); step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== {16'd0, 16'd12} || a_idx !== 16'd1)
      $display("FAIL cs1_row1: v=%b data=%h idx=%0d want 1 0000000c 1", a_valid, a_data, a_idx);
    else passes++;
    drv(2'b00, 16'd0, 16'd0); step();
    checks++;
    if (a_done !== 1'b1 || a_ovf !== 1'b0)
      $display("FAIL cs1_end: done=%b ovf=%b want 1 0", a_done, a_ovf);
    else passes++;
    step();
    set_col(16'd0);
    start_job(16'd1);
    drv(2'b11, 16'd33, 16'd44); step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== {16'd0, 16'd33})
      $display("FAIL cs0_row: v=%b data=%h want 1 00000021", a_valid, a_data);
    else passes++;
    drv(2'b00, 16'd0, 16'd0); step(); step();
    set_col(16'd99);
    start_job(16'd1);
    drv(2'b01, 16'd55, 16'd0); step();
    checks++;
    if (a_valid !== 1'b0) $display("FAIL cs99_wait: v=%b want 0", a_valid); else passes++;
    drv(2'b10, 16'd0, 16'd66); step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== {16'd66, 16'd55})
      $display("FAIL cs99_row: v=%b data=%h want 1 00420037", a_valid, a_data);
    else passes++;
    drv(2'b00, 16'd0, 16'd0); step(); step();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    start_job(16'd4);
    drv(2'b01, 16'd7, 16'd0); step();
    drv(2'b01, 16'd8, 16'd0); step();
    checks++;
    if (b_ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", b_ovf); else passes++;
    drv(2'b01, 16'd9, 16'd0); step();
    checks++;
    if (b_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", b_ovf); else passes++;
    drv(2'b10, 16'd0, 16'd17); step();
    drv(2'b10, 16'd0, 16'd18); step();
    drv(2'b00, 16'd0, 16'd0);
    out_ready = 1'b1;
    checks++;
    if (b_valid !== 1'b1 || b_data !== {16'd17, 16'd7} || b_idx !== 16'd0)
      $display("FAIL ovf_row0: v=%b data=%h idx=%0d want 1 00110007 0", b_valid, b_data, b_idx);
    else passes++;
    step();
    checks++;
    if (b_valid !== 1'b1 || b_data !== {16'd18, 16'd8} || b_idx !== 16'd1)
      $display("FAIL ovf_row1: v=%b data=%h idx=%0d want 1 00120008 1", b_valid, b_data, b_idx);
    else passes++;
    step();
    checks++;
    if (b_valid !== 1'b0) $display("FAIL ovf_drained: v=%b want 0", b_valid); else passes++;
    drv(2'b11, 16'd40, 16'd41); step();
    drv(2'b11, 16'd50, 16'd51);
    checks++;
    if (b_valid !== 1'b1 || b_data !== {16'd41, 16'd40} || b_idx !== 16'd2)
      $display("FAIL ovf_row2: v=%b data=%h idx=%0d want 1 00290028 2", b_valid, b_data, b_idx);
    else passes++;
    step();
    drv(2'b00, 16'd0, 16'd0);
    checks++;
    if (b_valid !== 1'b1 || b_data !== {16'd51, 16'd50} || b_idx !== 16'd3)
      $display("FAIL ovf_row3: v=%b data=%h idx=%0d want 1 00330032 3", b_valid, b_data, b_idx);
    else passes++;
    step();
    checks++;
    if (b_done !== 1'b1 || b_ovf !== 1'b1)
      $display("FAIL ovf_sticky: done=%b ovf=%b want 1 1", b_done, b_ovf);
    else passes++;
    step();
    start_job(16'd1);
    checks++;
    if (b_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", b_ovf); else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int dones;
    do_reset();
    start_job(16'd2);
    out_ready = 1'b1;
    drv(2'b11, 16'd1, 16'd2); step();
    drv(2'b00, 16'd0, 16'd0); step();
    checks++;
    if (a_idx !== 16'd1 || a_busy !== 1'b1)
      $display("FAIL mid_progress: idx=%0d busy=%b want 1 1", a_idx, a_busy);
    else passes++;
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({a_data, a_valid, a_idx, a_busy, a_done, a_ovf} !== '0)
      $display("FAIL mid_reset: data=%h v=%b idx=%0d busy=%b done=%b want all 0",
               a_data, a_valid, a_idx, a_busy, a_done);
    else passes++;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      if (a_done) dones++;
      step();
    end
    checks++;
    if (dones !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", dones); else passes++;
    start_job(16'd1);
    drv(2'b11, 16'd5, 16'd6); step();
    drv(2'b00, 16'd0, 16'd0);
    checks++;
    if (a_valid !== 1'b1 || a_data !== {16'd6, 16'd5} || a_idx !== 16'd0)
      $display("FAIL mid_fresh: v=%b data=%h idx=%0d want 1 00060005 0", a_valid, a_data, a_idx);
    else passes++;
    step();
    checks++;
    if (a_done !== 1'b1) $display("FAIL mid_fresh_done: got %b want 1", a_done); else passes++;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_zero_and_ignored_start();
    do_reset();
    start_job(16'd0);
    checks++;
    if (a_done !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL zero_rows: done=%b v=%b busy=%b want 1 0 0", a_done, a_valid, a_busy);
    else passes++;
    step();
    start_job(16'd2);
    out_ready = 1'b1;
    start = 1'b1; row_count = 16'd1;
    drv(2'b11, 16'd1, 16'd2); step();
    start = 1'b0;
    drv(2'b11, 16'd3, 16'd4);
    checks++;
    if (a_valid !== 1'b1 || a_idx !== 16'd0) $display("FAIL ign_row0: v=%b idx=%0d want 1 0", a_valid, a_idx);
    else passes++;
    step();
    drv(2'b00, 16'd0, 16'd0);
    checks++;
    if (a_done !== 1'b0 || a_valid !== 1'b1 || a_idx !== 16'd1 || a_data !== {16'd4, 16'd3})
      $display("FAIL ign_row1: done=%b v=%b idx=%0d data=%h want 0 1 1 00040003", a_done, a_valid, a_idx, a_data);
    else passes++;
    step();
    checks++;
    if (a_done !== 1'b1) $display("FAIL ign_done: got %b want 1", a_done); else passes++;
    step();
    out_ready = 1'b0;
  endtask

  // Random skewed stream, reference rows built from per-row sample tables.
  task automatic test_random_stream(input int iter);
    logic [15:0] dd [0:31][0:1];
    logic [15:0] raw;
    logic [31:0] exp_row;
    int n, eff, seen, dones, first_t, last_t, k;
    do_reset();
    case ($urandom_range(0, 3))
      0: raw = 16'd0;
      1: raw = 16'd1;
      2: raw = 16'd2;
      default: raw = 16'($urandom_range(3, 16'hffff));
    endcase
    eff = (raw == 0) ? 1 : (raw > 16'(W)) ? W : int'(raw);
    n = $urandom_range(5, 20);
    for (int r = 0; r < n; r++) begin
      dd[r][0] = 16'($urandom);
      dd[r][1] = 16'($urandom);
    end
    set_col(raw);
    start_job(16'(n));
    out_ready = 1'b1;
    seen = 0; dones = 0; first_t = -1; last_t = -1;
    for (int t = 0; t < n + 8; t++) begin
      sys_valid = '0;
      sys_data  = '0;
      for (int c = 0; c < W; c++) begin
        k = t - c;
        if (c < eff) begin
          if (k >= 0 && k < n) begin
            sys_valid[c] = 1'b1;
            sys_data[c*DW +: DW] = dd[k][c];
          end
        end else begin
          sys_valid[c] = 1'($urandom);
          sys_data[c*DW +: DW] = 16'($urandom);
        end
      end
      step();
      if (a_valid) begin
        exp_row = {(eff > 1) ? dd[seen][1] : 16'd0, dd[seen][0]};
        checks++;
        if (a_data !== exp_row || a_idx !== 16'(seen))
          $display("FAIL rand%0d_row%0d: data=%h idx=%0d want %h %0d", iter, seen, a_data, a_idx, exp_row, seen);
        else passes++;
        if (first_t < 0) first_t = t;
        last_t = t;
        if (seen < 31) seen++;
      end
      if (a_done) dones++;
    end
    checks++;
    if (seen !== n || dones !== 1)
      $display("FAIL rand%0d_count: rows=%0d done=%0d want %0d 1", iter, seen, dones, n);
    else passes++;
    checks++;
    if (last_t - first_t !== n - 1)
      $display("FAIL rand%0d_rate: span=%0d want %0d", iter, last_t - first_t, n - 1);
    else passes++;
    drv(2'b00, 16'd0, 16'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_col_size();
    test_overflow();
    test_reset_mid_job();
    test_zero_and_ignored_start();
    for (int i = 0; i < 6; i++) test_random_stream(i);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
